// File: rtl/ttt_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : ttt_game_controller
// Description : Tic-tac-toe game engine. Synchronises the active-low mouse
//               click, maps press positions onto the on-screen 3x3 grid,
//               enforces turn order, detects wins/draws, keeps saturating
//               scores and holds each result before the next round.
// Ports       : clock, globalResetn (async, active-low)
//               displayState   - display top state; play only in ACTIVE_STATE
//               mouse_xpos/ypos- pointer position
//               mouse_click    - active-low button, asynchronous
//               o_status/x_status - board occupancy per player (bit = cell)
//               o_score/x_score   - saturating round counts
//               game_state     - 0 IDLE, 1 PLAYING, 2 WIN, 3 DRAW
//               x_turn         - 1 when X moves next
//               win_line       - one bit per completed line
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_game_controller #(
    parameter logic [3:0] ACTIVE_STATE = 4'b0011,
    parameter int         HOLD_CYCLES  = 25_000_000,
    parameter int         SCORE_MAX    = 31
) (
    input  logic       clock,
    input  logic       globalResetn,
    input  logic [3:0] displayState,
    input  logic [7:0] mouse_xpos,
    input  logic [8:0] mouse_ypos,
    input  logic       mouse_click,
    output logic [8:0] o_status,
    output logic [8:0] x_status,
    output logic [4:0] o_score,
    output logic [4:0] x_score,
    output logic [1:0] game_state,
    output logic       x_turn,
    output logic [7:0] win_line
);

    localparam int              c_HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]      c_SCORE_MAX = 5'(SCORE_MAX);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PLAY   = 3'd1;
    localparam logic [2:0] c_ST_APPLY  = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_RESULT = 3'd4;

    // Line masks, line 0 in the least significant slice.
    localparam logic [71:0] c_LINES = {9'h054, 9'h111, 9'h124, 9'h092,
                                       9'h049, 9'h1C0, 9'h038, 9'h007};

    // ------------------------------------------------------------------
    // Click synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic r_sync1_q, r_sync2_q, r_hist_q;
    logic w_press;

    always_ff @(posedge clock or negedge globalResetn) begin
        if (!globalResetn) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_hist_q  <= 1'b1;
        end else begin
            r_sync1_q <= mouse_click;
            r_sync2_q <= r_sync1_q;
            r_hist_q  <= r_sync2_q;
        end
    end

    assign w_press = r_hist_q & ~r_sync2_q;

    // ------------------------------------------------------------------
    // Pointer to cell decode; gaps between bands are grid lines
    // ------------------------------------------------------------------
    logic [1:0] w_row, w_col;
    logic       w_row_ok, w_col_ok;
    logic [3:0] w_cell;

    always_comb begin
        w_row    = 2'd0;
        w_row_ok = 1'b1;
        if (mouse_xpos <= 8'd77)                              w_row = 2'd0;
        else if (mouse_xpos >= 8'd81 && mouse_xpos <= 8'd157) w_row = 2'd1;
        else if (mouse_xpos >= 8'd161 && mouse_xpos <= 8'd239) w_row = 2'd2;
        else                                                  w_row_ok = 1'b0;

        w_col    = 2'd0;
        w_col_ok = 1'b1;
        if (mouse_ypos >= 9'd41 && mouse_ypos <= 9'd118)       w_col = 2'd0;
        else if (mouse_ypos >= 9'd122 && mouse_ypos <= 9'd198) w_col = 2'd1;
        else if (mouse_ypos >= 9'd202 && mouse_ypos <= 9'd279) w_col = 2'd2;
        else                                                   w_col_ok = 1'b0;
    end

    assign w_cell = 4'(w_row) * 4'd3 + 4'(w_col);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]          state_q, state_d;
    logic [8:0]          r_o_q, r_o_d, r_x_q, r_x_d;
    logic [4:0]          r_os_q, r_os_d, r_xs_q, r_xs_d;
    logic [1:0]          r_gs_q, r_gs_d;
    logic                r_xt_q, r_xt_d;
    logic                r_start_x_q, r_start_x_d;
    logic [7:0]          r_win_q, r_win_d;
    logic [3:0]          r_cell_q, r_cell_d;
    logic [c_HOLD_W-1:0] r_hold_q, r_hold_d;

    logic       w_force_idle;
    logic       w_active;
    logic       w_occupied;
    logic       w_hold_done;
    logic [8:0] w_mover;
    logic [7:0] w_win;

    assign w_active     = (displayState == ACTIVE_STATE);
    assign w_force_idle = (state_q != c_ST_IDLE) && !w_active;
    assign w_occupied   = |((r_o_q | r_x_q) & (9'b1 << r_cell_q));
    assign w_hold_done  = (r_hold_q == c_HOLD_LAST);
    assign w_mover      = r_xt_q ? r_x_q : r_o_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lines
        assign w_win[gi] = ((w_mover & c_LINES[gi*9 +: 9]) == c_LINES[gi*9 +: 9]);
    end

    // State register
    always_ff @(posedge clock or negedge globalResetn) begin
        if (!globalResetn) state_q <= c_ST_IDLE;
        else               state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (w_force_idle) begin
            state_d = c_ST_IDLE;
        end else begin
            case (state_q)
                c_ST_IDLE:   if (w_active) state_d = c_ST_PLAY;
                c_ST_PLAY:   if (w_press && w_row_ok && w_col_ok) state_d = c_ST_APPLY;
                c_ST_APPLY:  state_d = w_occupied ? c_ST_PLAY : c_ST_CHECK;
                c_ST_CHECK:  state_d = ((|w_win) || ((r_o_q | r_x_q) == 9'h1FF))
                                       ? c_ST_RESULT : c_ST_PLAY;
                c_ST_RESULT: if (w_press && w_hold_done) state_d = c_ST_PLAY;
                default:     state_d = c_ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        r_o_d       = r_o_q;
        r_x_d       = r_x_q;
        r_os_d      = r_os_q;
        r_xs_d      = r_xs_q;
        r_gs_d      = r_gs_q;
        r_xt_d      = r_xt_q;
        r_start_x_d = r_start_x_q;
        r_win_d     = r_win_q;
        r_cell_d    = r_cell_q;
        r_hold_d    = '0;
        if (w_force_idle) begin
            // Leaving the game screen abandons the round but keeps scores.
            r_o_d       = '0;
            r_x_d       = '0;
            r_win_d     = '0;
            r_gs_d      = 2'd0;
            r_start_x_d = 1'b1;
            r_xt_d      = 1'b1;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (w_active) r_gs_d = 2'd1;
                end
                c_ST_PLAY: begin
                    if (w_press) r_cell_d = w_cell;
                end
                c_ST_APPLY: begin
                    if (!w_occupied) begin
                        if (r_xt_q) r_x_d = r_x_q | (9'b1 << r_cell_q);
                        else        r_o_d = r_o_q | (9'b1 << r_cell_q);
                    end
                end
                c_ST_CHECK: begin
                    if (|w_win) begin
                        // Simultaneous lines still score a single round.
                        if (r_xt_q) r_xs_d = (r_xs_q == c_SCORE_MAX) ? r_xs_q : r_xs_q + 5'd1;
                        else        r_os_d = (r_os_q == c_SCORE_MAX) ? r_os_q : r_os_q + 5'd1;
                        r_win_d = w_win;
                        r_gs_d  = 2'd2;
                    end else if ((r_o_q | r_x_q) == 9'h1FF) begin
                        r_gs_d = 2'd3;
                    end else begin
                        r_xt_d = ~r_xt_q;
                    end
                end
                c_ST_RESULT: begin
                    r_hold_d = w_hold_done ? r_hold_q : r_hold_q + c_HOLD_W'(1);
                    if (w_press && w_hold_done) begin
                        r_o_d       = '0;
                        r_x_d       = '0;
                        r_win_d     = '0;
                        r_start_x_d = ~r_start_x_q;
                        r_xt_d      = ~r_start_x_q;
                        r_gs_d      = 2'd1;
                        r_hold_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge globalResetn) begin
        if (!globalResetn) begin
            r_o_q       <= '0;
            r_x_q       <= '0;
            r_os_q      <= '0;
            r_xs_q      <= '0;
            r_gs_q      <= 2'd0;
            r_xt_q      <= 1'b1;
            r_start_x_q <= 1'b1;
            r_win_q     <= '0;
            r_cell_q    <= '0;
            r_hold_q    <= '0;
        end else begin
            r_o_q       <= r_o_d;
            r_x_q       <= r_x_d;
            r_os_q      <= r_os_d;
            r_xs_q      <= r_xs_d;
            r_gs_q      <= r_gs_d;
            r_xt_q      <= r_xt_d;
            r_start_x_q <= r_start_x_d;
            r_win_q     <= r_win_d;
            r_cell_q    <= r_cell_d;
            r_hold_q    <= r_hold_d;
        end
    end

    assign o_status   = r_o_q;
    assign x_status   = r_x_q;
    assign o_score    = r_os_q;
    assign x_score    = r_xs_q;
    assign game_state = r_gs_q;
    assign x_turn     = r_xt_q;
    assign win_line   = r_win_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_game_controller
// Description : Self-checking bench for ttt_game_controller: a scripted
//               opening game from a vector table, hand-written result/hold,
//               draw, saturation, display-drop and reset sequences, then
//               randomised clicks against a rule-level game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_game_controller;

    localparam int HOLD = 20;

    logic       clock = 1'b0;
    logic       globalResetn;
    logic [3:0] displayState;
    logic [7:0] mouse_xpos;
    logic [8:0] mouse_ypos;
    logic       mouse_click;
    logic [8:0] o_status, x_status;
    logic [4:0] o_score, x_score;
    logic [1:0] game_state;
    logic       x_turn;
    logic [7:0] win_line;

    ttt_game_controller #(
        .ACTIVE_STATE (4'b0011),
        .HOLD_CYCLES  (HOLD),
        .SCORE_MAX    (31)
    ) dut (
        .clock        (clock),
        .globalResetn (globalResetn),
        .displayState (displayState),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .mouse_click  (mouse_click),
        .o_status     (o_status),
        .x_status     (x_status),
        .o_score      (o_score),
        .x_score      (x_score),
        .game_state   (game_state),
        .x_turn       (x_turn),
        .win_line     (win_line)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model (game rules) ----------------
    localparam int M_IDLE = 0, M_PLAY = 1, M_RESULT = 2;
    logic [8:0] m_o, m_x;
    int         m_os, m_xs;
    int         m_gs;
    bit         m_xt, m_start, m_fresh;
    logic [7:0] m_win;
    int         m_mode;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int rx [3] = '{40, 120, 200};
    int cy [3] = '{80, 160, 240};
    int bx [10] = '{0, 77, 78, 80, 81, 157, 158, 160, 161, 239};
    int by [12] = '{40, 41, 118, 119, 121, 122, 198, 199, 201, 202, 279, 280};

    function automatic int band(int v, int a0, int a1, int b0, int b1, int c0, int c1);
        if (v >= a0 && v <= a1) return 0;
        if (v >= b0 && v <= b1) return 1;
        if (v >= c0 && v <= c1) return 2;
        return -1;
    endfunction

    function automatic int cell_of(int x, int y);
        int r = band(x, 0, 77, 81, 157, 161, 239);
        int c = band(y, 41, 118, 122, 198, 202, 279);
        if (r < 0 || c < 0) return -1;
        return r * 3 + c;
    endfunction

    task automatic model_reset();
        m_o = '0; m_x = '0; m_os = 0; m_xs = 0; m_gs = 0;
        m_xt = 1; m_start = 1; m_win = '0; m_mode = M_IDLE; m_fresh = 0;
    endtask

    task automatic model_drop();
        m_o = '0; m_x = '0; m_win = '0; m_gs = 0;
        m_xt = 1; m_start = 1; m_mode = M_IDLE;
    endtask

    task automatic model_activate();
        if (m_mode == M_IDLE) begin m_mode = M_PLAY; m_gs = 1; end
    endtask

    task automatic model_press(int x, int y, bit hold_elapsed);
        int c;
        int filled;
        logic [8:0] b;
        if (m_mode == M_PLAY) begin
            c = cell_of(x, y);
            if (c < 0) return;
            if (m_o[c] || m_x[c]) return;
            if (m_xt) m_x[c] = 1'b1; else m_o[c] = 1'b1;
            b = m_xt ? m_x : m_o;
            m_win = '0;
            for (int i = 0; i < 8; i++)
                if (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]) m_win[i] = 1'b1;
            filled = 0;
            for (int i = 0; i < 9; i++) if (m_o[i] || m_x[i]) filled++;
            if (m_win != 0) begin
                if (m_xt) m_xs = (m_xs < 31) ? m_xs + 1 : 31;
                else      m_os = (m_os < 31) ? m_os + 1 : 31;
                m_gs = 2; m_mode = M_RESULT; m_fresh = 1;
            end else if (filled == 9) begin
                m_gs = 3; m_mode = M_RESULT; m_fresh = 1;
            end else begin
                m_xt = !m_xt;
            end
        end else if (m_mode == M_RESULT) begin
            m_fresh = 0;
            if (hold_elapsed) begin
                m_o = '0; m_x = '0; m_win = '0;
                m_start = !m_start; m_xt = m_start;
                m_gs = 1; m_mode = M_PLAY;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_all(string tag);
        chk({tag, " x_status"},   int'(x_status),   int'(m_x));
        chk({tag, " o_status"},   int'(o_status),   int'(m_o));
        chk({tag, " x_score"},    int'(x_score),    m_xs);
        chk({tag, " o_score"},    int'(o_score),    m_os);
        chk({tag, " game_state"}, int'(game_state), m_gs);
        chk({tag, " x_turn"},     int'(x_turn),     int'(m_xt));
        chk({tag, " win_line"},   int'(win_line),   int'(m_win));
    endtask

    // ---------------- stimulus ----------------
    task automatic click(int x, int y);
        @(negedge clock);
        mouse_xpos  = 8'(x);
        mouse_ypos  = 9'(y);
        mouse_click = 1'b0;
        repeat (4) @(negedge clock);
        mouse_click = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic do_press(int x, int y, bit hold_elapsed, string tag);
        click(x, y);
        model_press(x, y, hold_elapsed);
        check_all(tag);
    endtask

    task automatic press_cell(int c, string tag);
        do_press(rx[c / 3], cy[c % 3], 1'b0, tag);
    endtask

    task automatic new_round(string tag);
        repeat (HOLD + 10) @(negedge clock);
        do_press(5, 5, 1'b1, tag);
    endtask

    task automatic o_win_round();
        if (m_start) begin
            press_cell(3, "ow"); press_cell(0, "ow"); press_cell(4, "ow");
            press_cell(1, "ow"); press_cell(8, "ow"); press_cell(2, "ow");
        end else begin
            press_cell(0, "ow"); press_cell(3, "ow"); press_cell(1, "ow");
            press_cell(4, "ow"); press_cell(2, "ow");
        end
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [8:0] xs;
        logic [8:0] os;
        logic       xt;
        logic [1:0] gs;
        logic [7:0] wl;
        logic [4:0] xsc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int sel, x, y;
        int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        bit seen;

        // X0, O4, X1, O8, X2 interleaved with grid-line, margin,
        // boundary and occupied-cell clicks that must change nothing.
        tbl[0]  = '{40,  80,  9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[1]  = '{79,  80,  9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[2]  = '{40,  300, 9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[3]  = '{40,  80,  9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[4]  = '{78,  100, 9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[5]  = '{100, 119, 9'h001, 9'h000, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[6]  = '{120, 160, 9'h001, 9'h010, 1'b1, 2'd1, 8'h00, 5'd0};
        tbl[7]  = '{77,  121, 9'h001, 9'h010, 1'b1, 2'd1, 8'h00, 5'd0};
        tbl[8]  = '{81,  122, 9'h001, 9'h010, 1'b1, 2'd1, 8'h00, 5'd0};
        tbl[9]  = '{40,  160, 9'h003, 9'h010, 1'b0, 2'd1, 8'h00, 5'd0};
        tbl[10] = '{239, 279, 9'h003, 9'h110, 1'b1, 2'd1, 8'h00, 5'd0};
        tbl[11] = '{0,   41,  9'h003, 9'h110, 1'b1, 2'd1, 8'h00, 5'd0};
        tbl[12] = '{40,  240, 9'h007, 9'h110, 1'b1, 2'd2, 8'h01, 5'd1};

        globalResetn = 1'b0;
        displayState = 4'd3;
        mouse_xpos   = '0;
        mouse_ypos   = '0;
        mouse_click  = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        check_all("reset");

        globalResetn = 1'b1;
        repeat (2) @(negedge clock);
        model_activate();
        check_all("enter play");

        for (int i = 0; i < 13; i++) begin
            click(tbl[i].x, tbl[i].y);
            model_press(tbl[i].x, tbl[i].y, 1'b0);
            chk($sformatf("vec%0d x_status", i),   int'(x_status),   int'(tbl[i].xs));
            chk($sformatf("vec%0d o_status", i),   int'(o_status),   int'(tbl[i].os));
            chk($sformatf("vec%0d x_turn", i),     int'(x_turn),     int'(tbl[i].xt));
            chk($sformatf("vec%0d game_state", i), int'(game_state), int'(tbl[i].gs));
            chk($sformatf("vec%0d win_line", i),   int'(win_line),   int'(tbl[i].wl));
            chk($sformatf("vec%0d x_score", i),    int'(x_score),    int'(tbl[i].xsc));
        end

        // Press during the hold window is ignored.
        do_press(120, 160, 1'b0, "early press");
        chk("early press state", int'(game_state), 2);

        // After the hold, any press starts a new round with O first.
        new_round("next round");
        chk("next round x_turn", int'(x_turn), 0);
        chk("next round boards", int'(x_status | o_status), 0);
        press_cell(0, "o first");

        // Leaving the game screen mid-round.
        @(negedge clock);
        displayState = 4'd2;
        @(negedge clock);
        model_drop();
        check_all("display drop");
        chk("drop keeps x_score", int'(x_score), 1);
        displayState = 4'd3;
        repeat (2) @(negedge clock);
        model_activate();
        check_all("display back");

        // Full board without a line.
        for (int i = 0; i < 9; i++) press_cell(draw_seq[i], "draw");
        chk("draw state", int'(game_state), 3);
        chk("draw x_score", int'(x_score), 1);
        chk("draw o_score", int'(o_score), 0);

        // 32 O wins; score must stop at 31.
        for (int r = 0; r < 32; r++) begin
            new_round("sat round");
            o_win_round();
        end
        chk("o_score saturated", int'(o_score), 31);
        chk("sat state", int'(game_state), 2);

        // Asynchronous reset while the FSM sits in CHECK.
        new_round("pre reset round");
        @(negedge clock);
        mouse_xpos  = 8'd200;
        mouse_ypos  = 9'd160;
        mouse_click = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if ((x_status | o_status) != 9'h000) seen = 1;
        end
        chk("reach CHECK within budget", int'(seen), 1);
        #1;
        globalResetn = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        mouse_click = 1'b1;
        @(negedge clock);
        globalResetn = 1'b1;
        repeat (3) @(negedge clock);
        model_activate();
        check_all("after reset");

        // Randomised play against the model.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(99) < 6) begin
                @(negedge clock);
                displayState = 4'($urandom_range(2));
                @(negedge clock);
                model_drop();
                check_all("rand drop");
                displayState = 4'd3;
                repeat (2) @(negedge clock);
                model_activate();
                check_all("rand back");
            end else begin
                sel = $urandom_range(2);
                if (sel == 0) begin
                    x = rx[$urandom_range(2)];
                    y = cy[$urandom_range(2)];
                end else if (sel == 1) begin
                    x = bx[$urandom_range(9)];
                    y = by[$urandom_range(11)];
                end else begin
                    x = $urandom_range(239);
                    y = $urandom_range(319);
                end
                if (m_mode == M_RESULT && !(m_fresh && $urandom_range(1) == 0)) begin
                    repeat (HOLD + 10) @(negedge clock);
                    do_press(x, y, 1'b1, "rand");
                end else begin
                    do_press(x, y, 1'b0, "rand");
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
